// File: rtl/hpdcache_flush_walker.sv
// hpdcache_flush_walker: walks the directory on flush-all and feeds each valid+dirty line to the flush controller
module hpdcache_flush_walker #(
    parameter int unsigned Sets       = 64,
    parameter int unsigned Ways       = 4,
    parameter int unsigned SetWidth   = (Sets > 1) ? $clog2(Sets) : 1,
    parameter int unsigned TagWidth   = 20,
    parameter int unsigned NlineWidth = TagWidth + SetWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     dir_read_o,
    output logic [SetWidth-1:0]      dir_read_set_o,
    input  logic                     dir_gnt_i,
    input  logic [Ways-1:0]          dir_valid_i,
    input  logic [Ways-1:0]          dir_dirty_i,
    input  logic [Ways*TagWidth-1:0] dir_tag_i,
    output logic                     dir_clean_o,
    output logic [SetWidth-1:0]      dir_clean_set_o,
    output logic [Ways-1:0]          dir_clean_way_o,
    output logic                     flush_alloc_o,
    input  logic                     flush_alloc_ready_i,
    output logic [NlineWidth-1:0]    flush_alloc_nline_o,
    output logic [Ways-1:0]          flush_alloc_way_o,
    input  logic                     flush_empty_i
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, ALLOC, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [SetWidth-1:0]      set_q, set_d;
    logic [Ways-1:0]          pend_q, pend_d, way_oh;
    logic [Ways*TagWidth-1:0] tag_q, tag_d;
    logic [TagWidth-1:0]      tag_sel;
    logic                     last_set;

    assign last_set = set_q == SetWidth'(Sets - 1);
    assign way_oh   = pend_q & (~pend_q + Ways'(1));

    // tag of the lowest pending way
    always_comb begin
        tag_sel = '0;
        for (int w = 0; w < Ways; w++)
            if (way_oh[w]) tag_sel = tag_q[w*TagWidth +: TagWidth];
    end

    // next-state and output decode
    always_comb begin
        state_d             = state_q;
        set_d               = set_q;
        pend_d              = pend_q;
        tag_d               = tag_q;
        busy_o              = state_q != IDLE;
        done_o              = 1'b0;
        dir_read_o          = 1'b0;
        dir_read_set_o      = '0;
        dir_clean_o         = 1'b0;
        dir_clean_set_o     = '0;
        dir_clean_way_o     = '0;
        flush_alloc_o       = 1'b0;
        flush_alloc_nline_o = '0;
        flush_alloc_way_o   = '0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = READ;
                set_d   = '0;
            end
            READ: begin
                dir_read_o     = 1'b1;
                dir_read_set_o = set_q;
                if (dir_gnt_i) state_d = CHECK;
            end
            CHECK: begin
                pend_d = dir_valid_i & dir_dirty_i;
                tag_d  = dir_tag_i;
            end
            ALLOC: begin
                flush_alloc_o       = 1'b1;
                flush_alloc_nline_o = {tag_sel, set_q};
                flush_alloc_way_o   = way_oh;
                if (flush_alloc_ready_i) begin
                    dir_clean_o     = 1'b1;
                    dir_clean_set_o = set_q;
                    dir_clean_way_o = way_oh;
                    pend_d          = pend_q & ~way_oh;
                end
            end
            DRAIN: if (flush_empty_i) begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == CHECK || (state_q == ALLOC && flush_alloc_ready_i)) begin
            state_d = |pend_d ? ALLOC : last_set ? DRAIN : READ;
            set_d   = (|pend_d || last_set) ? set_q : set_q + SetWidth'(1);
        end
    end

    // state, set counter, pending ways and latched tags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            pend_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// tb_hpdcache_flush_walker: vector table of directory images with a scoreboard of expected allocations
module tb_hpdcache_flush_walker;
    localparam int S = 4, W = 2, TW = 20, SW = 2, NW = 22;

    typedef struct {
        logic [S-1:0][W-1:0]         valid;
        logic [S-1:0][W-1:0]         dirty;
        logic [S-1:0][W-1:0][TW-1:0] tag;
        int gnt_set, gnt_n, rdy_n, empty_from, restart, exp_done;
        string name;
    } vec_t;

    typedef struct packed {
        logic [NW-1:0] nline;
        logic [W-1:0]  way;
    } exp_t;

    logic clk, rst_i, start_i, busy_o, done_o, dir_read_o, dir_gnt_i;
    logic [SW-1:0] dir_read_set_o, dir_clean_set_o, rset;
    logic [W-1:0] dir_valid_i, dir_dirty_i, dir_clean_way_o, flush_alloc_way_o;
    logic [W*TW-1:0] dir_tag_i;
    logic dir_clean_o, flush_alloc_o, flush_alloc_ready_i, flush_empty_i;
    logic [NW-1:0] flush_alloc_nline_o;

    vec_t cur;
    vec_t tbl[8];
    exp_t q[$];
    int nvec = 0, nerr = 0;

    hpdcache_flush_walker #(.Sets(S), .Ways(W), .TagWidth(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .dir_read_o(dir_read_o), .dir_read_set_o(dir_read_set_o), .dir_gnt_i(dir_gnt_i),
        .dir_valid_i(dir_valid_i), .dir_dirty_i(dir_dirty_i), .dir_tag_i(dir_tag_i),
        .dir_clean_o(dir_clean_o), .dir_clean_set_o(dir_clean_set_o), .dir_clean_way_o(dir_clean_way_o),
        .flush_alloc_o(flush_alloc_o), .flush_alloc_ready_i(flush_alloc_ready_i),
        .flush_alloc_nline_o(flush_alloc_nline_o), .flush_alloc_way_o(flush_alloc_way_o),
        .flush_empty_i(flush_empty_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // directory model: data for the set read in the previous cycle
    always @(posedge clk) rset <= dir_read_set_o;
    assign dir_valid_i = cur.valid[rset];
    assign dir_dirty_i = cur.dirty[rset];
    assign dir_tag_i   = cur.tag[rset];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t blank(input string n, input int d);
        vec_t v;
        v.valid = '0; v.dirty = '0; v.tag = '0;
        v.gnt_set = 0; v.gnt_n = 0; v.rdy_n = 0; v.empty_from = 0; v.restart = 0;
        v.exp_done = d; v.name = n;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({busy_o, done_o, dir_read_o, dir_read_set_o, dir_clean_o, dir_clean_set_o,
                    dir_clean_way_o, flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o});
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int gn, rn;
        logic pg, pr;
        logic [NW-1:0] pn;
        logic [W-1:0] pw;
        cur = v; gn = v.gnt_n; rn = v.rdy_n; pg = 0; pr = 0; pn = '0; pw = '0;
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++)
                if (v.valid[s][w] && v.dirty[s][w]) begin
                    e.nline = {v.tag[s][w], SW'(s)};
                    e.way   = W'(1 << w);
                    q.push_back(e);
                end
        @(negedge clk);
        start_i = 1; dir_gnt_i = 1; flush_alloc_ready_i = 1; flush_empty_i = v.empty_from == 0;
        for (int c = 1; c <= v.exp_done + 2; c++) begin
            @(negedge clk);
            start_i = v.restart != 0 && c >= v.restart && c < v.restart + 3;
            flush_empty_i = c >= v.empty_from;
            if (dir_read_o && dir_read_set_o == SW'(v.gnt_set) && gn > 0) begin
                dir_gnt_i = 0; gn--;
            end else dir_gnt_i = 1;
            if (flush_alloc_o && rn > 0) begin
                flush_alloc_ready_i = 0; rn--;
            end else flush_alloc_ready_i = 1;
            #1;
            if (c == 1) chk({v.name, ".first_read"}, {dir_read_o, dir_read_set_o}, {1'b1, 2'd0});
            chk({v.name, ".busy"}, busy_o, c <= v.exp_done);
            chk({v.name, ".done"}, done_o, c == v.exp_done);
            if (pg) chk({v.name, ".read_hold"}, {dir_read_o, dir_read_set_o}, {1'b1, SW'(v.gnt_set)});
            if (pr) chk({v.name, ".alloc_hold"}, {flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o}, {1'b1, pn, pw});
            if (flush_alloc_o && flush_alloc_ready_i) begin
                if (q.size() == 0) chk({v.name, ".unexpected_alloc"}, flush_alloc_nline_o, 0);
                else begin
                    e = q.pop_front();
                    chk({v.name, ".nline"}, flush_alloc_nline_o, e.nline);
                    chk({v.name, ".way"}, flush_alloc_way_o, e.way);
                    chk({v.name, ".clean"}, {dir_clean_o, dir_clean_set_o, dir_clean_way_o}, {1'b1, e.nline[SW-1:0], e.way});
                end
            end else chk({v.name, ".no_clean"}, dir_clean_o, 0);
            pg = dir_read_o && !dir_gnt_i;
            pr = flush_alloc_o && !flush_alloc_ready_i;
            pn = flush_alloc_nline_o;
            pw = flush_alloc_way_o;
        end
        chk({v.name, ".sb_left"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        rst_i = 1; start_i = 0; dir_gnt_i = 0; flush_alloc_ready_i = 0; flush_empty_i = 0;
        cur = blank("init", 0);
        tbl[0] = blank("clean", 9);
        tbl[1] = blank("one_dirty", 10);
        tbl[1].valid[2] = 2'b11; tbl[1].dirty[2] = 2'b10;
        tbl[1].tag[2][1] = 20'h1A; tbl[1].tag[2][0] = 20'hFFFFF;
        tbl[2] = blank("rdy_stall", 14);
        tbl[2].valid[0] = 2'b11; tbl[2].dirty[0] = 2'b11; tbl[2].rdy_n = 3;
        tbl[2].tag[0][0] = 20'h00111; tbl[2].tag[0][1] = 20'h00222;
        tbl[3] = blank("inv_dirty", 9);
        tbl[3].valid[1] = 2'b10; tbl[3].dirty[1] = 2'b01; tbl[3].tag[1][0] = 20'h77777;
        tbl[4] = blank("gnt_stall", 14);
        tbl[4].gnt_set = 3; tbl[4].gnt_n = 5;
        tbl[5] = blank("drain_wait", 17);
        tbl[5].valid[3][0] = 1; tbl[5].dirty[3][0] = 1; tbl[5].tag[3][0] = 20'hABCDE; tbl[5].empty_from = 17;
        tbl[6] = blank("restart", 10);
        tbl[6].valid[1][1] = 1; tbl[6].dirty[1][1] = 1; tbl[6].tag[1][1] = 20'h5A5A5; tbl[6].restart = 3;
        tbl[7] = blank("all_dirty", 17);
        tbl[7].valid = '1; tbl[7].dirty = '1;
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++) tbl[7].tag[s][w] = TW'($urandom);
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", outs(), 0);
        rst_i = 0;
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);
        cur = blank("rst_alloc", 0);
        cur.valid[0] = 2'b11; cur.dirty[0] = 2'b11; cur.tag[0][0] = 20'h33333;
        @(negedge clk);
        start_i = 1; dir_gnt_i = 1; flush_alloc_ready_i = 0; flush_empty_i = 1;
        @(negedge clk);
        start_i = 0;
        repeat (2) @(negedge clk);
        #1 chk("rst.alloc_live", {flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o}, {1'b1, 20'h33333, 2'd0, 2'b01});
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        #1 chk("rst.outputs", outs(), 0);
        chk("rst.no_clean", dir_clean_o, 0);
        @(negedge clk);
        #1 chk("rst.stay_idle", {busy_o, flush_alloc_o, dir_read_o}, 0);
        flush_alloc_ready_i = 1;
        run_vec(tbl[1]);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
